// File: rtl/manchester_rx_decoder_if.sv
// Signal bundle between a Manchester line front end and the receive decoder.
// The master drives the line and the controls; the slave (decoder) returns words, strobes and status.
`timescale 1ns/1ps
interface manchester_rx_decoder_if #(
    parameter int DATA_W = 8
);
    logic              ena;
    logic              mode;
    logic              line_in;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              code_err;
    logic              busy;
    logic [7:0]        err_count;

    modport master (
        output ena, mode, line_in,
        input  data_out, data_valid, code_err, busy, err_count
    );

    modport slave (
        input  ena, mode, line_in,
        output data_out, data_valid, code_err, busy, err_count
    );
endinterface

// File: rtl/manchester_rx_decoder.sv
// Oversampling Manchester receiver: start-symbol detect, MSB-first decode, code-violation flagging.
// Define MANCH_RX_ERRCNT_EN to build the saturating violation counter behind err_count.
`timescale 1ns/1ps
module manchester_rx_decoder #(
    parameter int HALF_BIT_CYCLES = 4,
    parameter int DATA_W          = 8
) (
    input logic                    clk,
    input logic                    rst,
    manchester_rx_decoder_if.slave bus
);
    localparam int H  = HALF_BIT_CYCLES;
    localparam int TW = $clog2(H);
    localparam int KW = $clog2(2 * DATA_W);
    // Timer counts down to zero, so a load of N-1 samples N cycles later.
    localparam logic [TW-1:0] T_HALF = TW'(H / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(H - 1);
    localparam logic [KW-1:0] K_LAST = KW'(2 * DATA_W - 1);

    typedef enum logic [2:0] {ARM, IDLE, START, DATA, DONE} state_t;
    state_t state, state_n;

    logic              sync1, line_s, line_s_d;
    logic [TW-1:0]     timer, arm_cnt;
    logic [KW-1:0]     half_idx;
    logic              first_half, mode_l;
    logic [DATA_W-1:0] word, data_out;
    logic              data_valid, code_err;
    logic [7:0]        err_count;
    logic              rise, tick, pair_end, bad_pair, dec_bit;

    assign rise     = line_s & ~line_s_d;
    assign tick     = (timer == '0);
    assign pair_end = half_idx[0];
    assign bad_pair = (first_half == line_s);
    // 802.3 takes the second half-bit, Thomas the first.
    assign dec_bit  = mode_l ? first_half : line_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b0;
            line_s   <= 1'b0;
            line_s_d <= 1'b0;
        end else begin
            sync1    <= bus.line_in;
            line_s   <= sync1;
            line_s_d <= line_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ARM;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            ARM:   if (!line_s && arm_cnt == T_HALF) state_n = IDLE;
            IDLE:  if (rise) state_n = START;
            START: if (tick) state_n = line_s ? DATA : ARM;
            DATA:  if (tick && pair_end) begin
                       if (bad_pair)               state_n = ARM;
                       else if (half_idx == K_LAST) state_n = DONE;
                   end
            DONE:  state_n = ARM;
            default: state_n = ARM;
        endcase
        if (!bus.ena) state_n = ARM;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer      <= '0;
            arm_cnt    <= '0;
            half_idx   <= '0;
            first_half <= 1'b0;
            mode_l     <= 1'b0;
            word       <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            code_err   <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            code_err   <= 1'b0;
            if (!bus.ena) begin
                timer    <= '0;
                arm_cnt  <= '0;
                half_idx <= '0;
            end else begin
                arm_cnt <= (state == ARM && !line_s) ? arm_cnt + 1'b1 : '0;
                case (state)
                    IDLE: if (rise) begin
                        timer    <= T_HALF;
                        mode_l   <= bus.mode;
                        half_idx <= '0;
                    end
                    START: timer <= tick ? T_FULL : timer - 1'b1;
                    DATA: begin
                        timer <= tick ? T_FULL : timer - 1'b1;
                        if (tick) begin
                            half_idx   <= half_idx + 1'b1;
                            first_half <= line_s;
                            if (pair_end) begin
                                if (bad_pair) begin
                                    code_err <= 1'b1;
                                end else begin
                                    word <= {word[DATA_W-2:0], dec_bit};
                                    if (half_idx == K_LAST) begin
                                        data_out   <= {word[DATA_W-2:0], dec_bit};
                                        data_valid <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef MANCH_RX_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (rst)                                err_count <= 8'h00;
        else if (code_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
`else
    assign err_count = 8'h00;
`endif

    assign bus.data_out   = data_out;
    assign bus.data_valid = data_valid;
    assign bus.code_err   = code_err;
    assign bus.busy       = (state == START) || (state == DATA) || (state == DONE);
    assign bus.err_count  = err_count;
endmodule

// File: tb/tb_manchester_rx_decoder.sv
// Directed bench for manchester_rx_decoder: IEEE-coded frames driven on line_in,
// expected words queued at send time and popped when data_valid strobes.
`timescale 1ns/1ps
module tb_manchester_rx_decoder;
    localparam int H  = 4;
    localparam int DW = 8;
`ifdef MANCH_RX_ERRCNT_EN
    localparam int EXP_ERRCNT = 1;
`else
    localparam int EXP_ERRCNT = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    manchester_rx_decoder_if #(.DATA_W(DW)) bus ();
    manchester_rx_decoder #(.HALF_BIT_CYCLES(H), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0, errors = 0, cerr_seen = 0, valid_seen = 0;
    logic [DW-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic half(input logic v);
        bus.line_in = v;
        tick(H);
    endtask

    // Start symbol then the first nsym symbols MSB-first; symbol 'bad' is sent as 11.
    task automatic send(input logic [DW-1:0] w, input int bad, input int nsym);
        half(1'b0);
        half(1'b1);
        for (int i = 0; i < nsym; i++) begin
            logic b;
            b = w[DW-1-i];
            if (i == bad) begin
                half(1'b1);
                half(1'b1);
            end else begin
                half(~b);
                half(b);
            end
        end
        bus.line_in = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick(1);
            n++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (bus.data_valid) begin
            valid_seen++;
            if (exp_q.size() == 0) chk("spurious_valid", bus.data_valid, 1'b0);
            else                   chk("data_out", bus.data_out, exp_q.pop_front());
        end
        if (bus.code_err) begin
            cerr_seen++;
            chk("valid_with_err", bus.data_valid, 1'b0);
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.ena = 1'b1;
        bus.mode = 1'b0;
        bus.line_in = 1'b0;
        tick(3);
        chk("rst_data_out", bus.data_out, 0);
        chk("rst_data_valid", bus.data_valid, 0);
        chk("rst_code_err", bus.code_err, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err_count", bus.err_count, 0);
        rst = 1'b0;
        tick(4);

        // IEEE decode
        exp_q.push_back(8'hB2);
        send(8'hB2, -1, DW);
        wait_drain("drain_b2");
        chk("cerr_after_b2", cerr_seen, 0);

        // Thomas decode of the same waveform; mode flips back mid-frame
        tick(4);
        bus.mode = 1'b1;
        exp_q.push_back(8'h4D);
        fork
            send(8'hB2, -1, DW);
            begin tick(20); bus.mode = 1'b0; end
        join
        wait_drain("drain_4d");
        chk("cerr_after_4d", cerr_seen, 0);

        // Violation on word bit 4; the frame is cut after the bad symbol so the
        // remaining symbols cannot be re-acquired as a new start edge.
        tick(4);
        send(8'hF0, 3, 4);
        tick(10);
        chk("cerr_violation", cerr_seen, 1);
        chk("hold_data_out", bus.data_out, 8'h4D);
        chk("err_count", bus.err_count, EXP_ERRCNT);
        chk("valid_count_3", valid_seen, 2);
        exp_q.push_back(8'h0F);
        send(8'h0F, -1, DW);
        wait_drain("drain_0f");

        // One-cycle glitch: start edge taken, then rejected silently
        tick(6);
        bus.line_in = 1'b1;
        tick(1);
        bus.line_in = 1'b0;
        tick(2);
        chk("glitch_busy_hi", bus.busy, 1);
        tick(5);
        chk("glitch_busy_lo", bus.busy, 0);
        chk("glitch_cerr", cerr_seen, 1);
        chk("glitch_valid", valid_seen, 3);

        // Reset during bit 3 of 0xA5
        tick(4);
        send(8'hA5, -1, 4);
        bus.line_in = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("midrst_data_out", bus.data_out, 0);
        chk("midrst_valid", bus.data_valid, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_err_count", bus.err_count, 0);
        bus.line_in = 1'b0;
        tick(8);
        exp_q.push_back(8'h3C);
        send(8'h3C, -1, DW);
        wait_drain("drain_3c");

        // Back-to-back frames with no gap
        tick(4);
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'h0F);
        send(8'hF0, -1, DW);
        send(8'h0F, -1, DW);
        wait_drain("drain_b2b");
        tick(4);
        chk("valid_total", valid_seen, 6);
        chk("cerr_total", cerr_seen, 1);
        chk("final_err_count", bus.err_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
